// File: rtl/key_sw_input_pio.sv
// Memory-mapped input port for four push-buttons and eighteen slide switches.
// Every input is synchronised and debounced on a slow sample tick. Key presses
// and any switch movement are latched as edge flags that can raise an interrupt.
// The processor sees four registers: data, a reserved word, irqmask and edge (W1C).
module key_sw_input_pio #(
  parameter int unsigned TICK_CYCLES  = 50000,
  parameter int unsigned STABLE_TICKS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  key_n,
  input  logic [17:0] sw,
  input  logic        chipselect,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        irq
);

  localparam int NB = 22;
  localparam int PW = $clog2(TICK_CYCLES);

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  // Keys are inverted so a pressed key reads as 1.
  logic [NB-1:0] raw_in;
  assign raw_in = {sw, ~key_n};

  logic [NB-1:0]      sync1_q, sync_q;
  logic [PW-1:0]      pre_q, pre_d;
  logic               tick;
  logic [NB-1:0]      db_q, db_d;
  logic [NB-1:0][3:0] cnt_q, cnt_d;
  logic               primed_q, primed_d;
  logic [NB-1:0]      edge_q, edge_d;
  logic [NB-1:0]      new_edge;
  logic [NB-1:0]      mask_q, mask_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               irq_q, irq_d;

  // Bits 31:22 of writedata have no register behind them.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^writedata[31:NB];

  // Terminal count of the free-running prescaler marks a sample tick.
  assign tick  = (pre_q == PW'(TICK_CYCLES - 1));
  assign pre_d = tick ? '0 : pre_q + PW'(1);

  // Debounce: a bit must differ from its accepted level for STABLE_TICKS
  // consecutive ticks before the new level is taken; any agreeing sample
  // (a bounce back) restarts the count. The first tick after reset just
  // copies the synchronised inputs so power-up levels produce no edges.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    db_d     = db_q;
    cnt_d    = cnt_q;
    primed_d = primed_q;
    if (tick) begin
      if (!primed_q) begin
        db_d     = sync_q;
        cnt_d    = '0;
        primed_d = 1'b1;
      end else begin
        for (int i = 0; i < NB; i++) begin
          if (sync_q[i] == db_q[i]) begin
            cnt_d[i] = 4'd0;
          end else if (cnt_q[i] + 4'd1 == 4'(STABLE_TICKS)) begin
            db_d[i]  = sync_q[i];
            cnt_d[i] = 4'd0;
          end else begin
            cnt_d[i] = cnt_q[i] + 4'd1;
          end
        end
      end
    end
  end

  // Keys flag only a press (0->1); switches flag movement in either direction.
  always_comb begin
    logic [NB-1:0] rise, change;
    rise     = db_d & ~db_q;
    change   = db_d ^ db_q;
    new_edge = primed_q ? {change[NB-1:4], rise[3:0]} : '0;
  end

  // Register file update: W1C edge clear loses to a simultaneous new edge,
  // irq is computed from next state so it tracks the registered edge/mask.
  always_comb begin
    logic [NB-1:0] clr;
    logic [31:0]   rd_mux;
    clr    = (chipselect && write && address == ADDR_EDGE) ? writedata[NB-1:0] : '0;
    edge_d = (edge_q & ~clr) | new_edge;
    mask_d = (chipselect && write && address == ADDR_MASK) ? writedata[NB-1:0] : mask_q;
    irq_d  = |(edge_d & mask_d);
    unique case (address)
      ADDR_DATA: rd_mux = {{(32-NB){1'b0}}, db_q};
      ADDR_RSVD: rd_mux = 32'd0;
      ADDR_MASK: rd_mux = {{(32-NB){1'b0}}, mask_q};
      ADDR_EDGE: rd_mux = {{(32-NB){1'b0}}, edge_q};
      default:   rd_mux = 32'd0;
    endcase
    readdata_d = (chipselect && read) ? rd_mux : readdata_q;
  end

  // All state, including the synchroniser, clears asynchronously on reset.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      sync1_q    <= '0;
      sync_q     <= '0;
      pre_q      <= '0;
      db_q       <= '0;
      cnt_q      <= '0;
      primed_q   <= 1'b0;
      edge_q     <= '0;
      mask_q     <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= raw_in;
      sync_q     <= sync1_q;
      pre_q      <= pre_d;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      primed_q   <= primed_d;
      edge_q     <= edge_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_key_sw_input_pio.sv
// Bench for key_sw_input_pio with a short tick: directed scenarios with literal
// expectations, then random input/bus traffic against a tick-level model.
module tb_key_sw_input_pio;

  localparam int TICK = 4;
  localparam int ST   = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  key_n;
  logic [17:0] sw;
  logic        chipselect;
  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  always #5 clk = ~clk;

  key_sw_input_pio #(.TICK_CYCLES(TICK), .STABLE_TICKS(ST)) dut (
    .clk(clk), .reset(reset), .key_n(key_n), .sw(sw),
    .chipselect(chipselect), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .irq(irq)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: raw inputs delayed two clocks, a tick every TICK
  // clocks, per-bit disagreement counts, latched edges and mask.
  logic [21:0] m_s1, m_s2, m_db, m_edge, m_mask;
  int          m_pre;
  bit          m_primed;
  int          m_cnt [22];
  logic [31:0] m_rd;
  logic        m_irq;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0; m_edge = '0; m_mask = '0;
    m_pre = 0; m_primed = 0; m_rd = '0; m_irq = 1'b0;
    for (int i = 0; i < 22; i++) m_cnt[i] = 0;
  endtask

  task automatic model_step();
    logic [21:0] s_old, db_old, edge_old, mask_old, newe;
    bit tk;
    s_old = m_s2; db_old = m_db; edge_old = m_edge; mask_old = m_mask; newe = '0;
    tk = (m_pre == TICK - 1);
    if (tk) begin
      if (!m_primed) begin
        m_db = s_old;
        m_primed = 1;
        for (int i = 0; i < 22; i++) m_cnt[i] = 0;
      end else begin
        for (int i = 0; i < 22; i++) begin
          if (s_old[i] == m_db[i]) m_cnt[i] = 0;
          else begin
            m_cnt[i]++;
            if (m_cnt[i] >= ST) begin
              m_db[i] = s_old[i];
              m_cnt[i] = 0;
              if (i >= 4 || s_old[i]) newe[i] = 1'b1;
            end
          end
        end
      end
    end
    m_pre = tk ? 0 : m_pre + 1;
    m_s2  = m_s1;
    m_s1  = {sw, ~key_n};
    if (chipselect && write && address == 2'd2) m_mask = writedata[21:0];
    if (chipselect && write && address == 2'd3) m_edge = m_edge & ~writedata[21:0];
    m_edge = m_edge | newe;
    if (chipselect && read) begin
      case (address)
        2'd0: m_rd = {10'd0, db_old};
        2'd1: m_rd = 32'd0;
        2'd2: m_rd = {10'd0, mask_old};
        default: m_rd = {10'd0, edge_old};
      endcase
    end
    m_irq = |(m_edge & m_mask);
  endtask

  // True when the coming clock edge will latch a new key0 press.
  function automatic bit pred_key0_edge();
    return (m_pre == TICK - 1) && m_primed && m_s2[0] && !m_db[0] && (m_cnt[0] + 1 >= ST);
  endfunction

  // One clock: advance the model with the pre-edge inputs, then compare.
  task automatic cycle();
    @(posedge clk);
    if (reset) model_reset();
    else model_step();
    #1;
    check("readdata", readdata, m_rd);
    check("irq", {31'd0, irq}, {31'd0, m_irq});
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) cycle();
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    cycle();
    chipselect = 1'b0; write = 1'b0; writedata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] exp, input string name);
    chipselect = 1'b1; read = 1'b1; address = a;
    cycle();
    chipselect = 1'b0; read = 1'b0;
    check(name, readdata, exp);
  endtask

  // Asserts reset between clock edges, then checks the asynchronous clear.
  task automatic async_reset(input int hold);
    #2 reset = 1'b1;
    model_reset();
    #1;
    check("async_reset_readdata", readdata, 32'd0);
    check("async_reset_irq", {31'd0, irq}, 32'd0);
    wait_cycles(hold);
    reset = 1'b0;
  endtask

  initial begin
    bit found;
    reset = 1'b1; key_n = 4'hF; sw = 18'h3FFFF;
    chipselect = 1'b0; address = 2'd0; read = 1'b0; write = 1'b0; writedata = '0;
    model_reset();
    wait_cycles(3);
    reset = 1'b0;

    // Power-up levels are captured by the first tick without edges.
    wait_cycles(8);
    bus_read(2'd0, 32'h003F_FFF0, "prime_data");
    bus_read(2'd3, 32'h0, "prime_edge");
    check("prime_irq", {31'd0, irq}, 32'd0);

    // Key0 press debounces, flags an edge, and raises irq once masked.
    key_n = 4'hE;
    wait_cycles(20);
    bus_read(2'd0, 32'h003F_FFF1, "key0_data");
    bus_read(2'd3, 32'h1, "key0_edge");
    bus_write(2'd2, 32'h1);
    check("key0_irq", {31'd0, irq}, 32'd1);

    // Single-tick glitch on key1 never reaches the debounced level.
    bus_write(2'd3, 32'h1);
    check("clear_irq", {31'd0, irq}, 32'd0);
    key_n = 4'hC;
    wait_cycles(4);
    key_n = 4'hE;
    wait_cycles(20);
    bus_read(2'd0, 32'h003F_FFF1, "glitch_data");
    bus_read(2'd3, 32'h0, "glitch_edge");

    // Re-establish edge0, then collide a W1C with the next key0 press.
    key_n = 4'hF; wait_cycles(20);
    key_n = 4'hE; wait_cycles(20);
    bus_read(2'd3, 32'h1, "pre_collide_edge");
    key_n = 4'hF; wait_cycles(20);
    key_n = 4'hE;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (pred_key0_edge()) begin
        bus_write(2'd3, 32'h1);
        found = 1;
        break;
      end
      cycle();
    end
    check("collide_found", {31'd0, found}, 32'd1);
    bus_read(2'd3, 32'h1, "collide_edge_kept");
    bus_write(2'd3, 32'h1);
    bus_read(2'd3, 32'h0, "w1c_edge");
    check("w1c_irq", {31'd0, irq}, 32'd0);

    // Masked switch edge, mask write latency, reserved word, read hold.
    bus_write(2'd2, 32'h0);
    sw = 18'h3FFFE;
    wait_cycles(20);
    bus_read(2'd3, 32'h10, "sw0_edge");
    check("sw0_irq_masked", {31'd0, irq}, 32'd0);
    bus_write(2'd2, 32'h10);
    check("mask_irq_next", {31'd0, irq}, 32'd1);
    bus_read(2'd2, 32'h10, "mask_read");
    cycle();
    check("read_hold", readdata, 32'h10);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd1, 32'h0, "rsvd_read");

    // Reset in the middle of a sw[5] debounce count.
    bus_write(2'd3, 32'h003F_FFFF);
    sw = 18'h3FFDE;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (m_cnt[9] == 1) begin
        found = 1;
        break;
      end
    end
    check("partial_count_found", {31'd0, found}, 32'd1);
    async_reset(3);
    bus_read(2'd0, 32'h0, "post_reset_data");
    bus_read(2'd1, 32'h0, "post_reset_rsvd");
    bus_read(2'd2, 32'h0, "post_reset_mask");
    bus_read(2'd3, 32'h0, "post_reset_edge");
    wait_cycles(30);
    bus_read(2'd3, 32'h0, "reprime_edge");
    bus_read(2'd0, 32'h003F_FDE1, "reprime_data");
    check("reprime_irq", {31'd0, irq}, 32'd0);

    // Random inputs and bus traffic, compared against the model every cycle.
    for (int n = 0; n < 3000; n++) begin
      int r;
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 21);
        if (r < 4) key_n[r] = ~key_n[r];
        else sw[r-4] = ~sw[r-4];
      end
      if ($urandom_range(0, 699) == 0) begin
        async_reset($urandom_range(1, 3));
      end
      r = $urandom_range(0, 9);
      address = 2'($urandom_range(0, 3));
      writedata = $urandom;
      chipselect = (r <= 4);
      read  = (r <= 2) || (r == 5);
      write = (r == 3) || (r == 4) || (r == 6);
      if (r == 3) address = 2'd2;
      if (r == 4) address = 2'd3;
      cycle();
      chipselect = 1'b0; read = 1'b0; write = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/key_sw_input_pio.md
KEY_SW_INPUT_PIO -- requirements
Module: key_sw_input_pio

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000, meaning clk cycles per debounce sample tick (1 ms at 50 MHz); legal range 2..2^20.
REQ-002 SHALL have parameter STABLE_TICKS, default 4, meaning consecutive differing samples required to accept a new level; legal range 1..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock, 50 MHz system clock.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port key_n, input, 4 bits: raw push-buttons, active-low, asynchronous to clk.
REQ-006 SHALL have port sw, input, 18 bits: raw slide switches, asynchronous to clk.
REQ-007 SHALL have port chipselect, input, 1 bit: Avalon-MM slave select.
REQ-008 SHALL have port address, input, 2 bits: word register address.
REQ-009 SHALL have port read, input, 1 bit: read strobe.
REQ-010 SHALL have port write, input, 1 bit: write strobe.
REQ-011 SHALL have port writedata, input, 32 bits: write data.
REQ-012 SHALL have port readdata, output, 32 bits: read data, registered.
REQ-013 SHALL have port irq, output, 1 bit: level interrupt to processor.

Function
REQ-014 SHALL form raw vector in[21:0] = {sw[17:0], ~key_n[3:0]}, so key bits read 1 when pressed.
REQ-015 SHALL pass every in bit through a two-flop synchronizer before any other use.
REQ-016 SHALL run a free prescaler counting 0..TICK_CYCLES-1 and pulse tick for one cycle at the terminal count, then wrap to 0.
REQ-017 SHALL keep per bit a debounced level db and a 4-bit counter; on tick: counter := 0 when sync == db, otherwise counter+1; counter reaching STABLE_TICKS sets db := sync and counter := 0.
REQ-018 SHALL treat a bounce (sync returning to db before STABLE_TICKS) as a counter clear with no db change.
REQ-019 SHALL hold a primed flag: the first tick after reset loads db := sync for all bits, sets primed, and generates no edges.
REQ-020 SHALL set edge[i] for key bits i=0..3 on a db 0->1 transition and for switch bits i=4..21 on any db transition.
REQ-021 SHALL clear edge bits via write of 1s to address 3 (W1C); writing 0 has no effect.
REQ-022 SHALL let set win when a new edge and a W1C clear hit the same bit in the same cycle.
REQ-023 SHALL implement registers: addr 0 = data, {10'b0, db}, read-only; addr 1 = reads 0, writes ignored; addr 2 = irqmask[21:0], RW; addr 3 = edge[21:0], read/W1C.
REQ-024 SHALL accept an access only when chipselect is high; read and write are never asserted together by the master.
REQ-025 SHALL return readdata one cycle after read with chipselect (read latency 1, no waitrequest) and hold the last value otherwise.
REQ-026 SHALL drive irq = |(edge & irqmask) from registered state; irq is asserted the cycle after the edge bit sets.
REQ-027 SHALL make a mask write take effect on irq the cycle after the write.

Reset
REQ-028 SHALL asynchronously clear on reset: synchronizers, prescaler, db, counters, primed, edge, irqmask, readdata, and irq, all to 0.
REQ-029 SHALL abort any partial debounce count on reset mid-operation; no edge SHALL survive or be produced by reset.
REQ-030 SHALL resume operation on reset deassertion with the prescaler at 0 and re-prime on the first tick.

Verification (TICK_CYCLES=4, STABLE_TICKS=2)
REQ-031 SHALL verify: sw=18'h3FFFF held through reset release -> data reads 0x003FFFF0 after first tick, edge reads 0, irq=0.
REQ-032 SHALL verify: key_n[0] 1->0 held -> db[0]=1 after 2 ticks plus sync latency; edge reads 0x1; with irqmask=0x1, irq=1.
REQ-033 SHALL verify: key_n[1] glitches low for 1 tick then returns high -> data bit1 stays 0 and edge stays 0.
REQ-034 SHALL verify: edge=0x1 with W1C 0x1 coinciding with a new key0 edge -> edge remains 0x1; a later W1C 0x1 -> edge 0, irq 0.
REQ-035 SHALL verify: irqmask=0 with edge=0x10 -> irq=0; write irqmask=0x10 -> irq=1 next cycle; read addr 1 -> 0; read latency exactly 1 cycle.
REQ-036 SHALL verify: reset asserted mid-count with sw[5] partially debounced -> all registers read 0 after release; no edge for sw[5] after re-prime.
